// File: rtl/mioc_test_pkg.sv
// Shared types and reference truth tables for the MIOC gate test blocks.
// Truth tables are indexed by input vector: bit v is the expected z for vector v.
package mioc_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] TT_XNOR2 = 4'b1001;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [1:0] TT_INV   = 2'b01;

endpackage

// File: rtl/mioc_sync2.sv
// Two-flop synchronizer for bringing an asynchronous single-bit signal into the clk domain.
module mioc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mioc_gate_stim_chk.sv
// Exhaustive stimulus generator and response checker for an N-input MIOC gate.
// Each vector is held for HOLD_CYCLES, then the synchronized output is compared to EXPECT.
module mioc_gate_stim_chk
    import mioc_test_pkg::*;
#(
    parameter int                 N           = 2,
    parameter int                 HOLD_CYCLES = 4,
    parameter logic [(2**N)-1:0]  EXPECT      = TT_XNOR2,
    parameter int                 CNT_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                z_in,
    output logic [N-1:0]        gate_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_count,
    output logic                first_fail_valid,
    output logic [N-1:0]        first_fail_vec,
    output logic [(2**N)-1:0]   z_table
);

    if (N < 1 || N > 4) begin : g_bad_n
        $error("mioc_gate_stim_chk: N must be in 1..4");
    end
    if (HOLD_CYCLES < 3) begin : g_bad_hold
        $error("mioc_gate_stim_chk: HOLD_CYCLES must be >= 3");
    end
    if (CNT_W < N + 1) begin : g_bad_cnt
        $error("mioc_gate_stim_chk: CNT_W must be >= N+1");
    end

    localparam int                 HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N-1:0]       LAST_VEC  = '1;

    state_t             state;
    state_t             next_state;
    logic [N-1:0]       vec;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               z_s;
    logic               start_pass;
    logic               sample_now;

    mioc_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (z_in),
        .q   (z_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start is only honoured between passes, so a glitch mid-pass cannot disturb the walk
    always_comb begin
        next_state = state;
        start_pass = 1'b0;
        sample_now = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = SETTLE;
                    start_pass = 1'b1;
                end
            end
            SETTLE: begin
                if (hold_cnt == HOLD_LAST) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_now = 1'b1;
                next_state = (vec == LAST_VEC) ? DONE : SETTLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec              <= '0;
            hold_cnt         <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            z_table          <= '0;
        end else if (start_pass) begin
            vec              <= '0;
            hold_cnt         <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            z_table          <= '0;
        end else if (state == SETTLE) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else if (sample_now) begin
            z_table[vec] <= z_s;
            hold_cnt     <= '0;
            // Vectors are walked in ascending order, so the first recorded failure is the lowest
            if (z_s != EXPECT[vec]) begin
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= vec;
                end
            end
            if (vec != LAST_VEC) begin
                vec <= vec + 1'b1;
            end
        end
    end

    assign busy    = (state == SETTLE) || (state == SAMPLE);
    assign done    = (state == DONE);
    assign pass    = done && (err_count == '0);
    assign gate_in = busy ? vec : '0;

endmodule

// File: tb/tb_mioc_gate_stim_chk.sv
// Directed bench for mioc_gate_stim_chk: default XNOR2 instance plus an N=1 inverter instance.
module tb_mioc_gate_stim_chk;
    import mioc_test_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start_b = 1'b0;
    logic       z_in;
    logic       z_in_b;
    logic [1:0] gate_in;
    logic       busy, done, pass, first_fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;
    logic [3:0] z_table;
    logic [0:0] gate_in_b;
    logic       busy_b, done_b, pass_b, first_fail_valid_b;
    logic [2:0] err_count_b;
    logic [0:0] first_fail_vec_b;
    logic [1:0] z_table_b;

    int         mode = 0;
    logic [1:0] z_dly;
    int         compare_count = 0;
    int         fail_count = 0;

    always #5 clk = ~clk;

    mioc_gate_stim_chk dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .z_in             (z_in),
        .gate_in          (gate_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .z_table          (z_table)
    );

    mioc_gate_stim_chk #(
        .N           (1),
        .HOLD_CYCLES (3),
        .EXPECT      (TT_INV),
        .CNT_W       (3)
    ) dut_inv (
        .clk              (clk),
        .rst              (rst),
        .start            (start_b),
        .z_in             (z_in_b),
        .gate_in          (gate_in_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_count_b),
        .first_fail_valid (first_fail_valid_b),
        .first_fail_vec   (first_fail_vec_b),
        .z_table          (z_table_b)
    );

    // Gate models: 0 ideal XNOR2, 1 stuck-at-0, 2 XOR2, 3 XNOR2 delayed two clocks
    always @(posedge clk) begin
        z_dly <= {z_dly[0], ~(gate_in[1] ^ gate_in[0])};
    end

    always_comb begin
        case (mode)
            0:       z_in = ~(gate_in[1] ^ gate_in[0]);
            1:       z_in = 1'b0;
            2:       z_in = gate_in[1] ^ gate_in[0];
            default: z_in = z_dly[1];
        endcase
    end

    assign z_in_b = ~gate_in_b[0];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accepts a start, then checks the vector walk edge by edge until done at +20
    task automatic applyStimulus(input bit glitch);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checkOutput("gate_in walk", gate_in, k / 5);
            checkOutput("busy during pass", busy, 1);
            checkOutput("done during pass", done, 0);
            if (glitch && (k == 3 || k == 10)) start = 1'b1;
            step();
            start = 1'b0;
        end
        checkOutput("done at +20", done, 1);
        checkOutput("busy at done", busy, 0);
        checkOutput("gate_in at done", gate_in, 0);
    endtask

    task automatic checkResults(input logic p, input logic [2:0] ec, input logic ffv,
                                input logic [1:0] ffvec, input logic [3:0] zt);
        checkOutput("pass", pass, p);
        checkOutput("err_count", err_count, ec);
        checkOutput("first_fail_valid", first_fail_valid, ffv);
        checkOutput("first_fail_vec", first_fail_vec, ffvec);
        checkOutput("z_table", z_table, zt);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " gate_in"}, gate_in, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
        checkResults(1'b0, 3'd0, 1'b0, 2'd0, 4'd0);
    endtask

    initial begin
        bit seen;

        // Reset state
        step();
        step();
        checkAllZero("reset");
        checkOutput("reset z_table_b", z_table_b, 0);
        rst = 1'b0;
        step();

        $display("[TB] ideal XNOR2");
        mode = 0;
        applyStimulus(1'b0);
        checkResults(1'b1, 3'd0, 1'b0, 2'd0, 4'b1001);

        $display("[TB] z stuck at 0");
        mode = 1;
        applyStimulus(1'b0);
        checkResults(1'b0, 3'd2, 1'b1, 2'd0, 4'b0000);

        $display("[TB] XOR2 against XNOR2 table");
        mode = 2;
        applyStimulus(1'b0);
        checkResults(1'b0, 3'd4, 1'b1, 2'd0, 4'b0110);

        $display("[TB] delayed XNOR2");
        mode = 3;
        applyStimulus(1'b0);
        checkResults(1'b1, 3'd0, 1'b0, 2'd0, 4'b1001);

        $display("[TB] reset mid-pass");
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        checkOutput("busy before abort", busy, 1);
        rst = 1'b1;
        #1;
        checkAllZero("abort");
        step();
        rst = 1'b0;
        step();
        checkAllZero("after abort");
        applyStimulus(1'b0);
        checkResults(1'b1, 3'd0, 1'b0, 2'd0, 4'b1001);

        $display("[TB] start pulses while busy");
        mode = 0;
        applyStimulus(1'b1);
        checkResults(1'b1, 3'd0, 1'b0, 2'd0, 4'b1001);

        $display("[TB] start held high through done");
        mode = 2;
        start = 1'b1;
        step();
        repeat (20) step();
        checkOutput("held done at +20", done, 1);
        checkResults(1'b0, 3'd4, 1'b1, 2'd0, 4'b0110);
        step();
        checkOutput("held done one cycle", done, 0);
        checkOutput("held busy reasserts", busy, 1);
        checkResults(1'b0, 3'd0, 1'b0, 2'd0, 4'b0000);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            seen = done;
        end
        checkOutput("held rerun completes", seen, 1);
        checkResults(1'b0, 3'd4, 1'b1, 2'd0, 4'b0110);

        $display("[TB] N=1 inverter");
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checkOutput("inv gate_in walk", gate_in_b, k / 4);
            checkOutput("inv done during pass", done_b, 0);
            step();
        end
        checkOutput("inv done at +8", done_b, 1);
        checkOutput("inv pass", pass_b, 1);
        checkOutput("inv err_count", err_count_b, 0);
        checkOutput("inv z_table", z_table_b, 2'b01);
        checkOutput("inv first_fail_valid", first_fail_valid_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
